// File: rtl/pcm_adc_pkg.sv
// pcm_adc_pkg: shared constants and helpers for the PCM1801/PCM1808 master-mode receiver.
// Build macro: PCM_ADC_RX_I2S_EN selects I2S framing (default left-justified).
package pcm_adc_pkg;

  // Frame geometry: SCKI/8 bit clock, SCKI/512 frame clock, 32 BCK per half-frame.
  localparam int FRAME_CLKS  = 512;
  localparam int BCK_DIV     = 8;
  localparam int SLOTS       = 32;
  localparam int PHASE_W     = 9;

  // Synchronised data becomes usable two flops after the BCK rising edge (p[2:0]=4).
  localparam int SHIFT_PHASE = 6;
  // Last cycle of the frame; every data bit has landed by now.
  localparam int LOAD_PHASE  = 511;

`ifdef PCM_ADC_RX_I2S_EN
  // I2S: one BCK of delay after the LRCK edge, LRCK low during the left half.
  localparam int first_slot  = 1;
  localparam bit LRCK_LEFT   = 1'b0;
`else
  // Left-justified: MSB in the first slot, LRCK high during the left half.
  localparam int first_slot  = 0;
  localparam bit LRCK_LEFT   = 1'b1;
`endif

  // True when the given slot of a half-frame carries one of the w_data captured bits.
  function automatic logic slot_has_data(input logic [4:0] slot, input int w_data);
    int s;
    s = int'(slot);
    return (s >= first_slot) && (s < first_slot + w_data);
  endfunction

  // LRCK level for a given half: p8 = 0 is the left half.
  function automatic logic lrck_level(input logic p8);
    return p8 ? ~LRCK_LEFT : LRCK_LEFT;
  endfunction

endpackage

// File: rtl/pcm_sync2.sv
// pcm_sync2: two-flop synchroniser for asynchronous board inputs into clk.
// Synchronous active-low reset clears both stages.
module pcm_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; meta_q may go metastable, sync_q is safe to use.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pcm_adc_rx.sv
// pcm_adc_rx: master-mode PCM1801/PCM1808 serial receiver in the SCKI domain.
// Generates BCK (clk/8) and LRCK (clk/512), deserialises DOUT MSB-first and
// presents each stereo pair with a one-cycle valid strobe at p = 0.
// Build macro: PCM_ADC_RX_I2S_EN selects I2S framing; undefined gives left-justified.
module pcm_adc_rx
  import pcm_adc_pkg::*;
#(
  parameter int w_data = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pcm_dout,
  output logic              pcm_bck,
  output logic              pcm_lrck,
  output logic [w_data-1:0] left,
  output logic [w_data-1:0] right,
  output logic              valid
);

  logic [PHASE_W-1:0] p_q;
  logic [PHASE_W-1:0] p_d;
  logic               bck_q;
  logic               lrck_q;
  logic [w_data-1:0]  sl_q;
  logic [w_data-1:0]  sr_q;
  logic [w_data-1:0]  left_q;
  logic [w_data-1:0]  right_q;
  logic               valid_q;

  logic               dout_s;
  logic [4:0]         slot;
  logic               shift_en;
  logic               load_en;

  pcm_sync2 u_sync_dout (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pcm_dout),
    .q     (dout_s)
  );

  // Next phase, slot decode and the shift/load enables for the current cycle.
  always_comb begin
    p_d      = p_q + 1'b1;
    slot     = p_q[7:3];
    shift_en = (p_q[2:0] == 3'(SHIFT_PHASE)) && slot_has_data(slot, w_data);
    load_en  = (p_q == PHASE_W'(LOAD_PHASE));
  end

  // Frame counter, clock outputs, shift registers, sample registers and strobe.
  // BCK/LRCK are registered from the next phase so they track p exactly with no
  // combinational path to the pads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q     <= '0;
      bck_q   <= 1'b0;
      lrck_q  <= LRCK_LEFT;
      sl_q    <= '0;
      sr_q    <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      bck_q  <= p_d[2];
      lrck_q <= lrck_level(p_d[8]);
      if (shift_en) begin
        if (p_q[8]) begin
          sr_q <= {sr_q[w_data-2:0], dout_s};
        end else begin
          sl_q <= {sl_q[w_data-2:0], dout_s};
        end
      end
      if (load_en) begin
        left_q  <= sl_q;
        right_q <= sr_q;
      end
      valid_q <= load_en;
    end
  end

  assign pcm_bck  = bck_q;
  assign pcm_lrck = lrck_q;
  assign left     = left_q;
  assign right    = right_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_pcm_adc_rx.sv
// tb_pcm_adc_rx: directed bench for pcm_adc_rx (w_data=24 and a w_data=16 instance).
// Honours PCM_ADC_RX_I2S_EN the same way the RTL does.
`timescale 1ns/1ps
module tb_pcm_adc_rx;

`ifdef PCM_ADC_RX_I2S_EN
  localparam bit BUILD_LJ = 1'b0;
`else
  localparam bit BUILD_LJ = 1'b1;
`endif
  localparam logic LRCK_RST = BUILD_LJ ? 1'b1 : 1'b0;
  localparam logic [23:0] TR_L = 24'h123456;
  localparam logic [23:0] TR_R = 24'hFEDCBA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dout24 = 1'b0;
  logic        dout16 = 1'b0;
  logic        bck, lrck, valid;
  logic        bck16, lrck16, valid16;
  logic [23:0] left, right;
  logic [15:0] left16, right16;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] src_l = 24'h800001;
  logic [23:0] src_r = 24'h7FFFFE;
  bit          fmt_lj_bfm = BUILD_LJ;
  bit          jitter_en = 1'b0;

  // BFM state
  bit bfm_left = 1'b1;
  int bfm_slot = 0;
  bit bck_prev = 1'b0;
  int hi_cnt = 0;
  int jit = 0;
  bit pend = 1'b0;

  always #21 clk = ~clk;

  pcm_adc_rx #(.w_data(24)) dut (
    .clk(clk), .rst_n(rst_n), .pcm_dout(dout24),
    .pcm_bck(bck), .pcm_lrck(lrck), .left(left), .right(right), .valid(valid)
  );

  pcm_adc_rx #(.w_data(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .pcm_dout(dout16),
    .pcm_bck(bck16), .pcm_lrck(lrck16), .left(left16), .right(right16), .valid(valid16)
  );

  function automatic logic bitval(input logic [23:0] w, input int slot, input bit lj);
    logic [23:0] ww;
    ww = w;
    if (lj) return (slot < 24) ? ww[23 - slot] : 1'b0;
    return (slot >= 1 && slot <= 24) ? ww[24 - slot] : 1'b0;
  endfunction

  task automatic drive_bits(input bit lh, input int s);
    dout24 = bitval(lh ? src_l : src_r, s, fmt_lj_bfm);
    dout16 = bitval(lh ? TR_L : TR_R, s, fmt_lj_bfm);
  endtask

  // Slave ADC model: changes DOUT after each BCK falling edge, optionally one
  // cycle early or late.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bfm_left = 1'b1;
      bfm_slot = 0;
      hi_cnt   = 0;
      pend     = 1'b0;
      jit      = 0;
      drive_bits(1'b1, 0);
    end else begin
      if (bck_prev && !bck) begin
        if (bfm_slot == 31) begin
          bfm_slot = 0;
          bfm_left = !bfm_left;
        end else begin
          bfm_slot++;
        end
        if (jit == 0) drive_bits(bfm_left, bfm_slot);
        else if (jit == 1) pend = 1'b1;
      end else if (pend) begin
        drive_bits(bfm_left, bfm_slot);
        pend = 1'b0;
      end
      hi_cnt = bck ? hi_cnt + 1 : 0;
      if (hi_cnt == 4) begin
        jit = jitter_en ? int'($urandom_range(2)) - 1 : 0;
        if (jit == -1) begin
          if (bfm_slot == 31) drive_bits(!bfm_left, 0);
          else drive_bits(bfm_left, bfm_slot + 1);
        end
      end
    end
    bck_prev = bck;
  end

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid !== 1'b1 && n < budget);
    if (valid !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL valid_timeout: no valid within %0d cycles", budget);
      n = -1;
    end
  endtask

  task automatic test_lj;
    int n;
    int n2;
    wait_valid(1100, n);
    n_checks++; if (n !== 512) begin n_fail++; $display("FAIL first_valid: got cycle %0d exp 512", n); end
    n_checks++; if (left !== 24'h800001) begin n_fail++; $display("FAIL lj_left: got %h exp 800001", left); end
    n_checks++; if (right !== 24'h7FFFFE) begin n_fail++; $display("FAIL lj_right: got %h exp 7ffffe", right); end
    n_checks++; if (valid16 !== 1'b1) begin n_fail++; $display("FAIL valid16_align: got %b exp 1", valid16); end
    n_checks++; if (left16 !== 16'h1234) begin n_fail++; $display("FAIL trunc_left: got %h exp 1234", left16); end
    n_checks++; if (right16 !== 16'hFEDC) begin n_fail++; $display("FAIL trunc_right: got %h exp fedc", right16); end
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle: got %b exp 0", valid); end
    repeat (250) @(negedge clk);
    n_checks++; if (left !== 24'h800001 || right !== 24'h7FFFFE) begin
      n_fail++; $display("FAIL hold_between: got %h/%h exp 800001/7ffffe", left, right);
    end
    wait_valid(1100, n2);
    n_checks++; if (251 + n2 !== 512) begin n_fail++; $display("FAIL valid_period: got %0d exp 512", 251 + n2); end
  endtask

  task automatic test_back_to_back;
    int n;
    for (int f = 0; f < 3; f++) begin
      wait_valid(1100, n);
      n_checks++;
      if (n !== 512 || left !== 24'h800001 || right !== 24'h7FFFFE) begin
        n_fail++;
        $display("FAIL b2b_frame%0d: got period %0d data %h/%h exp 512 800001/7ffffe", f, n, left, right);
      end
    end
  endtask

  task automatic test_reset;
    bit early;
    early = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (bck !== 1'b0) begin n_fail++; $display("FAIL rst_bck: got %b exp 0", bck); end
    n_checks++; if (lrck !== LRCK_RST) begin n_fail++; $display("FAIL rst_lrck: got %b exp %b", lrck, LRCK_RST); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", valid); end
    n_checks++; if (left !== 24'h0 || right !== 24'h0) begin
      n_fail++; $display("FAIL rst_data: got %h/%h exp 0/0", left, right);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      if (k == 3) begin
        n_checks++; if (bck !== 1'b0) begin n_fail++; $display("FAIL bck_c3: got %b exp 0", bck); end
      end
      if (k == 4) begin
        n_checks++; if (bck !== 1'b1) begin n_fail++; $display("FAIL bck_c4: got %b exp 1", bck); end
      end
      if (k == 255) begin
        n_checks++; if (lrck !== LRCK_RST) begin n_fail++; $display("FAIL lrck_c255: got %b exp %b", lrck, LRCK_RST); end
      end
      if (k == 256) begin
        n_checks++; if (lrck !== ~LRCK_RST) begin n_fail++; $display("FAIL lrck_c256: got %b exp %b", lrck, ~LRCK_RST); end
      end
      if (k < 512 && valid === 1'b1) early = 1'b1;
      if (k == 512) begin
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL valid_c512: got %b exp 1", valid); end
      end
    end
    n_checks++; if (early) begin n_fail++; $display("FAIL early_valid: got strobe before cycle 512 exp none"); end
  endtask

  task automatic test_mid_frame_reset;
    int n;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    src_l = 24'hA5C3F0;
    src_r = 24'h0F1E2D;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(1100, n);
    n_checks++; if (n !== 512) begin n_fail++; $display("FAIL midrst_timing: got %0d exp 512", n); end
    n_checks++; if (left !== 24'hA5C3F0 || right !== 24'h0F1E2D) begin
      n_fail++; $display("FAIL midrst_data: got %h/%h exp a5c3f0/0f1e2d", left, right);
    end
  endtask

  task automatic test_cross_format;
    int n;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
    exp_l = BUILD_LJ ? 24'h400000 : 24'h000002;
    exp_r = BUILD_LJ ? 24'h3FFFFF : 24'hFFFFFC;
    rst_n = 1'b0;
    src_l = 24'h800001;
    src_r = 24'h7FFFFE;
    fmt_lj_bfm = !BUILD_LJ;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(1100, n);
    n_checks++; if (left !== exp_l || right !== exp_r) begin
      n_fail++; $display("FAIL cross_format: got %h/%h exp %h/%h", left, right, exp_l, exp_r);
    end
  endtask

  task automatic test_jitter;
    int n;
    rst_n = 1'b0;
    fmt_lj_bfm = BUILD_LJ;
    jitter_en = 1'b1;
    src_l = 24'h5A3C96;
    src_r = 24'hC3A55A;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 100; f++) begin
      wait_valid(1100, n);
      n_checks++;
      if (n !== 512 || left !== 24'h5A3C96 || right !== 24'hC3A55A ||
          left16 !== 16'h1234 || right16 !== 16'hFEDC) begin
        n_fail++;
        $display("FAIL jitter_frame%0d: got %0d %h/%h %h/%h exp 512 5a3c96/c3a55a 1234/fedc",
                 f, n, left, right, left16, right16);
      end
    end
    jitter_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    test_lj();
    test_back_to_back();
    test_reset();
    test_mid_frame_reset();
    test_cross_format();
    test_jitter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
